sync_fifo_reader: RTL and testbench

Read-side adapter for the team's standard-mode synchronous FIFO. The FIFO presents registered data_out one cycle after rd_en and exposes an empty flag. This block owns the FIFO's read port and re-presents the data as a valid/ready stream with no bubbles, using a small skid buffer that absorbs the one-cycle read latency. It sits between any sync_fifo_cnt instance and a downstream consumer that may stall at any time.

---
 rtl/sync_fifo_reader.sv | 105 ++++++++++
 tb/tb_sync_fifo_reader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_reader.sv
// Read-side adapter for a registered-output synchronous FIFO: issues reads ahead
// of demand and re-presents the words as a bubble-free valid/ready stream.
module sync_fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int SKID_DEPTH = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  out_cnt
);

  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(SKID_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_V  = CW'(SKID_DEPTH);

  logic [DATA_WIDTH-1:0] buf_q [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] buf_d [SKID_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         buf_cnt_q, buf_cnt_d;
  logic                  infl_q, infl_d;
  logic                  drop_q, drop_d;
  logic [CNT_WIDTH-1:0]  out_cnt_q, out_cnt_d;

  logic                  rd_issue;
  logic                  wr_en;
  logic                  xfer;
  logic [CW:0]           occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Stream handshake: a word moves on every rising edge where m_valid && m_ready;
  // m_valid never depends on m_ready, and m_data/m_valid hold while stalled.
  always_comb begin
    occ      = {1'b0, buf_cnt_q} + {{CW{1'b0}}, infl_q};
    // Occupancy counts the word still in flight, so the buffer can never overflow.
    rd_issue = rst_n && !fifo_empty && !flush && (occ < {1'b0, DEPTH_V});
    wr_en    = infl_q && !drop_q && !flush;
    xfer     = (buf_cnt_q != '0) && m_ready;

    buf_d     = buf_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    buf_cnt_d = buf_cnt_q;
    out_cnt_d = out_cnt_q;
    infl_d    = rd_issue;
    drop_d    = flush && infl_q;

    if (xfer) out_cnt_d = out_cnt_q + 1'b1;

    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      buf_cnt_d = '0;
    end else begin
      if (wr_en) begin
        buf_d[wr_ptr_q] = fifo_data_out;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (xfer) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_en, xfer})
        2'b10:   buf_cnt_d = buf_cnt_q + 1'b1;
        2'b01:   buf_cnt_d = buf_cnt_q - 1'b1;
        default: buf_cnt_d = buf_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) buf_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      buf_cnt_q <= '0;
      infl_q    <= 1'b0;
      drop_q    <= 1'b0;
      out_cnt_q <= '0;
    end else begin
      for (int i = 0; i < SKID_DEPTH; i++) buf_q[i] <= buf_d[i];
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      buf_cnt_q <= buf_cnt_d;
      infl_q    <= infl_d;
      drop_q    <= drop_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  assign fifo_rd_en = rd_issue;
  assign m_valid    = (buf_cnt_q != '0);
  assign m_data     = buf_q[rd_ptr_q];
  assign out_cnt    = out_cnt_q;

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Self-checking bench for sync_fifo_reader: an 8-deep registered-output FIFO model
// feeds the DUT and a scoreboard checks every word delivered on the stream.
module tb_sync_fifo_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty;
  logic [7:0]  fifo_data_out;
  logic        fifo_rd_en;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic [15:0] out_cnt;

  logic        fifo_wr;
  logic [7:0]  fifo_wdata;
  logic        fifo_clr;

  sync_fifo_reader #(.DATA_WIDTH(8), .SKID_DEPTH(3), .CNT_WIDTH(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_rd_en    (fifo_rd_en),
    .flush         (flush),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .out_cnt       (out_cnt)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // 8-deep FIFO model, data registered one cycle after rd_en
  logic [7:0] fmem [8];
  logic [7:0] fdout = '0;
  int fcnt = 0, frp = 0, fwp = 0, pops = 0, uflow = 0, oflow = 0;

  assign fifo_empty    = (fcnt == 0);
  assign fifo_data_out = fdout;

  always @(posedge clk) begin
    int c;
    if (fifo_clr) begin
      fcnt <= 0;
      frp  <= 0;
      fwp  <= 0;
    end else begin
      c = fcnt;
      if (fifo_rd_en) begin
        if (c == 0) uflow <= uflow + 1;
        else begin
          fdout <= fmem[frp];
          frp   <= (frp + 1) % 8;
          c     = c - 1;
          pops  <= pops + 1;
        end
      end
      if (fifo_wr) begin
        if (fcnt == 8 && !fifo_rd_en) oflow <= oflow + 1;
        else begin
          fmem[fwp] <= fifo_wdata;
          fwp       <= (fwp + 1) % 8;
          c         = c + 1;
        end
      end
      fcnt <= c;
    end
  end

  // scoreboard and checking
  logic [7:0]  exp_q[$];
  logic [15:0] exp_cnt = '0;
  int n_checks = 0, n_pass = 0;
  int xfer_n = 0, xfer_run = 0, max_run = 0;
  logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_flush = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_flush = 1'b0;
      xfer_run   = 0;
    end else begin
      check("rd_while_empty", 32'(fifo_rd_en && fifo_empty), 32'd0);
      check("out_cnt", 32'(out_cnt), 32'(exp_cnt));
      if (prev_valid && !prev_ready && !prev_flush) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("sb_underrun", 32'd1, 32'd0);
        else check("m_data", 32'(m_data), 32'(exp_q.pop_front()));
        exp_cnt++;
        xfer_n++;
        xfer_run++;
        if (xfer_run > max_run) max_run = xfer_run;
      end else begin
        xfer_run = 0;
      end
      prev_valid = m_valid;
      prev_ready = m_ready;
      prev_flush = flush;
      prev_data  = m_data;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    fifo_wr    = 1'b1;
    fifo_wdata = d;
    exp_q.push_back(d);
    tick();
    fifo_wr = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while (i < budget && !(exp_q.size() == 0 && !m_valid)) begin
      tick();
      i++;
    end
    check("drain", 32'(exp_q.size() == 0 && !m_valid), 32'd1);
  endtask

  logic [7:0] words [8] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12};

  initial begin
    int base;
    int base_x;
    bit found;

    rst_n = 1'b0; m_ready = 1'b0; flush = 1'b0;
    fifo_wr = 1'b0; fifo_wdata = '0; fifo_clr = 1'b1;
    repeat (3) tick();
    fifo_clr = 1'b0;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_out_cnt", 32'(out_cnt), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    rst_n = 1'b1;
    tick();

    // 8 words streamed with the consumer always ready
    m_ready = 1'b1;
    max_run = 0;
    for (int i = 0; i < 8; i++) push_word(words[i]);
    wait_drain(50);
    check("t1_out_cnt", 32'(out_cnt), 32'd8);
    check("t1_run", 32'(max_run), 32'd8);

    // consumer stalled: only SKID_DEPTH reads issued
    m_ready = 1'b0;
    base = pops;
    for (int i = 0; i < 8; i++) push_word(words[i]);
    repeat (10) tick();
    check("t2_reads", 32'(pops - base), 32'd3);
    check("t2_fcnt", 32'(fcnt), 32'd5);
    check("t2_valid", 32'(m_valid), 32'd1);
    check("t2_head", 32'(m_data), 32'h24);
    max_run = 0;
    m_ready = 1'b1;
    wait_drain(60);
    check("t2_run", 32'(max_run), 32'd8);
    check("t2_out_cnt", 32'(out_cnt), 32'd16);

    // continuous write/read for 40 cycles
    max_run = 0;
    for (int i = 0; i < 40; i++) push_word(8'($urandom_range(0, 255)));
    wait_drain(60);
    check("t3_run", 32'(max_run), 32'd40);
    check("t3_out_cnt", 32'(out_cnt), 32'd56);
    check("t3_oflow", 32'(oflow), 32'd0);
    check("t3_uflow", 32'(uflow), 32'd0);

    // m_ready toggling while streaming
    base_x = xfer_n;
    for (int i = 0; i < 100; i++) begin
      m_ready = (i % 2 == 0);
      if (i < 8) begin
        fifo_wr    = 1'b1;
        fifo_wdata = words[i];
        exp_q.push_back(words[i]);
      end else begin
        fifo_wr = 1'b0;
      end
      tick();
      if (i >= 8 && exp_q.size() == 0 && !m_valid) break;
    end
    fifo_wr = 1'b0;
    check("t4_xfers", 32'(xfer_n - base_x), 32'd8);
    check("t4_out_cnt", 32'(out_cnt), 32'd64);

    // flush with 2 words buffered and one read in flight
    m_ready = 1'b0;
    m_ready = 1'b0;
    base   = pops;
    base_x = xfer_n;
    found  = 1'b0;
    fork
      begin
        for (int j = 0; j < 8; j++) push_word(words[j]);
      end
    join_none
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pops - base == 3) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_setup", 32'(found), 32'd1);
    flush = 1'b1;
    repeat (3) void'(exp_q.pop_front());
    tick();
    flush = 1'b0;
    check("t5_valid_n1", 32'(m_valid), 32'd0);
    check("t5_out_cnt", 32'(out_cnt), 32'd64);
    tick();
    check("t5_valid_n2", 32'(m_valid), 32'd0);
    tick();
    check("t5_valid_n3", 32'(m_valid), 32'd1);
    check("t5_data_n3", 32'(m_data), 32'h63);
    m_ready = 1'b1;
    wait fork;
    wait_drain(60);
    check("t5_xfers", 32'(xfer_n - base_x), 32'd5);
    check("t5_out_cnt_end", 32'(out_cnt), 32'd69);

    // asynchronous reset in the middle of a stream
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(words[i]);
    m_ready = 1'b1;
    tick();
    tick();
    check("t6_pre_valid", 32'(m_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(m_valid), 32'd0);
    check("t6_out_cnt", 32'(out_cnt), 32'd0);
    check("t6_rd_en", 32'(fifo_rd_en), 32'd0);
    check("t6_m_data", 32'(m_data), 32'd0);
    exp_q.delete();
    exp_cnt  = '0;
    fifo_clr = 1'b1;
    tick();
    tick();
    fifo_clr = 1'b0;
    rst_n    = 1'b1;
    tick();
    check("t6_post_valid", 32'(m_valid), 32'd0);
    check("t6_post_cnt", 32'(out_cnt), 32'd0);

    // report
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
